// File: rtl/core101_adder_pkg.sv
// Shared constants and width helpers for the core101 pipelined adder family.
package core101_adder_pkg;

   localparam logic ADDER_OP_ADD = 1'b0;
   localparam logic ADDER_OP_SUB = 1'b1;

   localparam int unsigned DEF_DATA_WIDTH = 64;
   localparam int unsigned DEF_STAGES     = 4;

   function automatic int unsigned seg_w(input int unsigned dw, input int unsigned st);
      return (st == 0) ? dw : dw / st;
   endfunction

   // Segment offset of stage k's operand skew slot (stage k holds n-1-k segments).
   function automatic int unsigned skew_off(input int unsigned k, input int unsigned n);
      int unsigned acc;
      acc = 0;
      for (int unsigned i = 0; i < k; i++) acc += n - 1 - i;
      return acc;
   endfunction

   // Segment offset of stage k's result deskew slot (stage k holds k segments).
   function automatic int unsigned desk_off(input int unsigned k);
      int unsigned acc;
      acc = 0;
      for (int unsigned i = 1; i < k; i++) acc += i;
      return acc;
   endfunction

endpackage

// File: rtl/adder_segment.sv
// One registered carry segment: sum and carry-out captured when enabled.
module adder_segment #(
   parameter int unsigned SEG_W = 16
) (
   input  logic             clock_in,
   input  logic             reset_n_in,
   input  logic             i_en,
   input  logic [SEG_W-1:0] i_a,
   input  logic [SEG_W-1:0] i_b,
   input  logic             i_cin,
   output logic [SEG_W-1:0] o_sum,
   output logic             o_cout
);

   logic [SEG_W:0]   w_full;
   logic [SEG_W-1:0] r_sum;
   logic             r_cout;

   assign w_full = {1'b0, i_a} + {1'b0, i_b} + (SEG_W+1)'(i_cin);

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else if (i_en) begin
         r_sum  <= w_full[SEG_W-1:0];
         r_cout <= w_full[SEG_W];
      end
   end

   assign o_sum  = r_sum;
   assign o_cout = r_cout;

endmodule

// File: rtl/pipelined_adder.sv
// Lockstep STAGES-deep segmented add/sub with valid/ready on both sides.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder
   import core101_adder_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned STAGES     = DEF_STAGES
) (
   input  logic                  clock_in,
   input  logic                  reset_n_in,
   input  logic                  adder_valid_in,
   output logic                  adder_ready_out,
   input  logic [DATA_WIDTH-1:0] adder_A_data_in,
   input  logic [DATA_WIDTH-1:0] adder_B_data_in,
   input  logic                  adder_sub_in,
   input  logic                  adder_carry_in,
   output logic                  adder_valid_out,
   input  logic                  adder_ready_in,
   output logic [DATA_WIDTH-1:0] adder_data_out,
   output logic                  adder_carry_out
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic                  adder_overflow_out
`endif
);

   localparam int unsigned SEG_W = seg_w(DATA_WIDTH, STAGES);
   localparam int unsigned TRI   = STAGES * (STAGES - 1) / 2;
   localparam int unsigned SK_W  = (TRI == 0) ? SEG_W : TRI * SEG_W;

   if (STAGES == 0 || (DATA_WIDTH % STAGES) != 0) begin : g_bad_param
      $error("pipelined_adder: DATA_WIDTH must be a nonzero multiple of STAGES");
   end

   logic                  w_adv;
   logic [DATA_WIDTH-1:0] w_b_eff;
   logic                  w_cin0;
   logic [STAGES-1:0]     r_vld;
   logic [SEG_W-1:0]      w_seg_a [STAGES];
   logic [SEG_W-1:0]      w_seg_b [STAGES];
   logic [STAGES-1:0]     w_seg_ci;
   logic [SEG_W-1:0]      w_sum   [STAGES];
   logic [STAGES-1:0]     w_co;
   logic [SK_W-1:0]       r_skew_a, r_skew_b, r_desk;
   logic [SK_W-1:0]       w_skew_a_nxt, w_skew_b_nxt, w_desk_nxt;

   assign w_adv           = !adder_valid_out || adder_ready_in;
   assign adder_ready_out = w_adv;
   assign adder_valid_out = r_vld[STAGES-1];
   assign w_b_eff         = (adder_sub_in == ADDER_OP_SUB) ? ~adder_B_data_in : adder_B_data_in;
   assign w_cin0          = (adder_sub_in == ADDER_OP_SUB) ? 1'b1 : adder_carry_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned UP = STAGES - 1 - k;

      if (k == 0) begin : g_first
         assign w_seg_a[k]  = adder_A_data_in[SEG_W-1:0];
         assign w_seg_b[k]  = w_b_eff[SEG_W-1:0];
         assign w_seg_ci[k] = w_cin0;
      end else begin : g_next
         localparam int unsigned OP = skew_off(k - 1, STAGES) * SEG_W;
         assign w_seg_a[k]  = r_skew_a[OP +: SEG_W];
         assign w_seg_b[k]  = r_skew_b[OP +: SEG_W];
         assign w_seg_ci[k] = w_co[k-1];
      end

      // Upper operand segments wait in skew slots until their stage is reached.
      if (UP > 0) begin : g_skew
         localparam int unsigned OS = skew_off(k, STAGES) * SEG_W;
         if (k == 0) begin : g_load
            assign w_skew_a_nxt[OS +: UP*SEG_W] = adder_A_data_in[DATA_WIDTH-1:SEG_W];
            assign w_skew_b_nxt[OS +: UP*SEG_W] = w_b_eff[DATA_WIDTH-1:SEG_W];
         end else begin : g_shift
            localparam int unsigned OP = skew_off(k - 1, STAGES) * SEG_W;
            assign w_skew_a_nxt[OS +: UP*SEG_W] = r_skew_a[OP+SEG_W +: UP*SEG_W];
            assign w_skew_b_nxt[OS +: UP*SEG_W] = r_skew_b[OP+SEG_W +: UP*SEG_W];
         end
      end

      // Finished lower result segments ride along in deskew slots.
      if (k == 1) begin : g_desk_first
         assign w_desk_nxt[desk_off(1)*SEG_W +: SEG_W] = w_sum[0];
      end else if (k > 1) begin : g_desk_shift
         assign w_desk_nxt[desk_off(k)*SEG_W +: k*SEG_W] =
            {w_sum[k-1], r_desk[desk_off(k-1)*SEG_W +: (k-1)*SEG_W]};
      end

      adder_segment #(.SEG_W(SEG_W)) u_seg (
         .clock_in   (clock_in),
         .reset_n_in (reset_n_in),
         .i_en       (w_adv),
         .i_a        (w_seg_a[k]),
         .i_b        (w_seg_b[k]),
         .i_cin      (w_seg_ci[k]),
         .o_sum      (w_sum[k]),
         .o_cout     (w_co[k])
      );
   end

   if (STAGES == 1) begin : g_out_single
      assign w_skew_a_nxt   = '0;
      assign w_skew_b_nxt   = '0;
      assign w_desk_nxt     = '0;
      assign adder_data_out = w_sum[0];
   end else begin : g_out_multi
      assign adder_data_out = {w_sum[STAGES-1],
                               r_desk[desk_off(STAGES-1)*SEG_W +: (STAGES-1)*SEG_W]};
   end

   assign adder_carry_out = w_co[STAGES-1];

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_vld    <= '0;
         r_skew_a <= '0;
         r_skew_b <= '0;
         r_desk   <= '0;
      end else if (w_adv) begin
         r_vld    <= STAGES'({r_vld, adder_valid_in});
         r_skew_a <= w_skew_a_nxt;
         r_skew_b <= w_skew_b_nxt;
         r_desk   <= w_desk_nxt;
      end
   end

`ifdef PIPELINED_ADDER_OVF_EN
   // Carry into the MSB is recovered as a^b^sum at that bit.
   logic r_msb_x;

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_msb_x <= 1'b0;
      end else if (w_adv) begin
         r_msb_x <= w_seg_a[STAGES-1][SEG_W-1] ^ w_seg_b[STAGES-1][SEG_W-1];
      end
   end

   assign adder_overflow_out = r_msb_x ^ w_sum[STAGES-1][SEG_W-1] ^ w_co[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (64-bit, 4 stages), including overflow when enabled.
module tb_pipelined_adder;

   logic        clk, rst_n, vin, rdy_out, sub, cin, vout, rdy_in, co;
   logic [63:0] a, b, dout;
`ifdef PIPELINED_ADDER_OVF_EN
   logic        ovf;
`endif

   int          n_checks, n_fail;
   int          sent, got, stale;
   logic        pend, stalled;
   logic [63:0] held, e_sum;
   logic        e_co;
   logic [64:0] m;
   logic [63:0] q_sum[$];
   logic        q_co[$];

   pipelined_adder #(.DATA_WIDTH(64), .STAGES(4)) dut (
      .clock_in        (clk),
      .reset_n_in      (rst_n),
      .adder_valid_in  (vin),
      .adder_ready_out (rdy_out),
      .adder_A_data_in (a),
      .adder_B_data_in (b),
      .adder_sub_in    (sub),
      .adder_carry_in  (cin),
      .adder_valid_out (vout),
      .adder_ready_in  (rdy_in),
      .adder_data_out  (dout),
      .adder_carry_out (co)
`ifdef PIPELINED_ADDER_OVF_EN
      ,
      .adder_overflow_out (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [64:0] model(input logic [63:0] x, input logic [63:0] y,
                                         input logic s, input logic c);
      logic [63:0] yy;
      yy = s ? ~y : y;
      return {1'b0, x} + {1'b0, yy} + 65'(s ? 1'b1 : c);
   endfunction

   // Single op with no backpressure; starts and ends 1 time unit after a rising edge.
   task automatic run_op(input string tag, input logic [63:0] xa, input logic [63:0] xb,
                         input logic xs, input logic xc, input logic [63:0] es, input logic ec);
      a = xa; b = xb; sub = xs; cin = xc; vin = 1'b1;
      check({tag, "_rdy"}, 64'(rdy_out), 64'd1);
      @(posedge clk); #1;
      vin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_early"}, 64'(vout), 64'd0);
      @(posedge clk); #1;
      check({tag, "_vld"}, 64'(vout), 64'd1);
      check({tag, "_sum"}, dout, es);
      check({tag, "_co"}, 64'(co), 64'(ec));
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      rst_n = 1'b0; vin = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; rdy_in = 1'b1;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset_vld", 64'(vout), 64'd0);
      check("reset_data", dout, 64'd0);
      check("reset_co", 64'(co), 64'd0);
      check("reset_rdy", 64'(rdy_out), 64'd1);
`ifdef PIPELINED_ADDER_OVF_EN
      check("reset_ovf", 64'(ovf), 64'd0);
`endif

      run_op("seg_carry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0);
      run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1);
`ifdef PIPELINED_ADDER_OVF_EN
      check("wrap_ovf", 64'(ovf), 64'd0);
`endif
      run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0);
`ifdef PIPELINED_ADDER_OVF_EN
      check("sovf_ovf", 64'(ovf), 64'd1);
`endif
      run_op("sub_neg", 64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      run_op("sub_pos", 64'd7, 64'd5, 1'b1, 1'b0, 64'd2, 1'b1);
      run_op("add_cin", 64'd1, 64'd1, 1'b0, 1'b1, 64'd3, 1'b0);
      run_op("sub_cin_ign", 64'd9, 64'd9, 1'b1, 1'b0, 64'd0, 1'b1);

      // Drain, then stall the output with a second op queued behind the first.
      @(posedge clk); #1;
      check("drain_vld", 64'(vout), 64'd0);
      rdy_in = 1'b0;
      a = 64'h1234; b = 64'h1111; sub = 1'b0; cin = 1'b0; vin = 1'b1;
      @(posedge clk); #1;
      a = 64'h100; b = 64'h1; sub = 1'b1;
      @(posedge clk); #1;
      vin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("stall_vld", 64'(vout), 64'd1);
      check("stall_sum1", dout, 64'h2345);
      check("stall_rdy", 64'(rdy_out), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("stall_hold_vld", 64'(vout), 64'd1);
      check("stall_hold_sum", dout, 64'h2345);
      rdy_in = 1'b1;
      @(posedge clk); #1;
      check("stall_next_vld", 64'(vout), 64'd1);
      check("stall_next_sum", dout, 64'hFF);
      check("stall_next_co", 64'(co), 64'd1);
      @(posedge clk); #1;
      check("stall_empty", 64'(vout), 64'd0);

      // Random ops under random output backpressure against a scoreboard.
      sent = 0; got = 0; pend = 1'b0; stalled = 1'b0; held = '0;
      for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
         rdy_in = 1'($urandom_range(0, 1));
         if (!pend && sent < 16) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            pend = 1'b1;
         end
         vin = pend;
         @(negedge clk);
         if (stalled) check("rnd_stall_hold", dout, held);
         if (vout && rdy_in) begin
            if (q_sum.size() == 0) begin
               check("rnd_spurious", 64'(vout), 64'd0);
            end else begin
               e_sum = q_sum.pop_front();
               e_co  = q_co.pop_front();
               check("rnd_sum", dout, e_sum);
               check("rnd_co", 64'(co), 64'(e_co));
            end
            got++;
         end
         if (vin && rdy_out) begin
            m = model(a, b, sub, cin);
            q_sum.push_back(m[63:0]);
            q_co.push_back(m[64]);
            sent++;
            pend = 1'b0;
         end
         stalled = vout && !rdy_in;
         held = dout;
         @(posedge clk); #1;
      end
      vin = 1'b0; rdy_in = 1'b1;
      check("rnd_count", 64'(got), 64'd16);
      check("rnd_left", 64'(q_sum.size()), 64'd0);

      // Asynchronous reset with work in flight.
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         a = 64'(i + 1); b = 64'd10; sub = 1'b0; cin = 1'b0; vin = 1'b1;
         @(posedge clk); #1;
      end
      vin = 1'b0;
      check("rst_pre_vld", 64'(vout), 64'd1);
      check("rst_pre_data", dout, 64'd12);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_vld", 64'(vout), 64'd0);
      check("rst_async_data", dout, 64'd0);
      check("rst_async_co", 64'(co), 64'd0);
      @(posedge clk);
      #4 rst_n = 1'b1;
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         if (vout) stale++;
      end
      check("rst_no_stale", 64'(stale), 64'd0);
      check("rst_rdy", 64'(rdy_out), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
